snd_pdm_rx: RTL and testbench

- PDM-to-PCM receiver for the cartridge audio path; the receive-side counterpart of the sound DAC.
- Generates the bit clock for an external PDM source (e.g. a MEMS mic), samples the 1-bit stream, and decimates it with a 3rd-order CIC filter.
- Delivers 16-bit signed PCM on a valid/ready port for the mixer/capture logic, all on the single fast clock domain.

---
 rtl/snd_pkg.sv | 10 +
 rtl/snd_pdm_rx_if.sv | 12 +
 rtl/snd_cic_decim.sv | 75 +++++++
 rtl/snd_pdm_rx.sv | 113 +++++++++++
 tb/tb_snd_pdm_rx.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/snd_pkg.sv
// snd_pkg: shared PCM sample type, CIC/DC-block constants and 16-bit saturation for the sound path
package snd_pkg;
   localparam int PCM_W     = 16;
   localparam int CIC_ORDER = 3;
   localparam int DC_SHIFT  = 8;
   typedef logic signed [PCM_W-1:0] pcm_t;
   function automatic pcm_t sat16(input logic signed [31:0] v);
      return (v > 32'sd32767) ? 16'sh7fff : (v < -32'sd32768) ? 16'sh8000 : pcm_t'(v[15:0]);
   endfunction
endpackage

// File: rtl/snd_pdm_rx_if.sv
// snd_pdm_rx_if: PCM sample stream with valid/ready handshake
//   pcm_data  : signed PCM sample (master -> slave)
//   pcm_valid : pcm_data holds an unconsumed sample (master -> slave)
//   pcm_ready : slave accepts the sample when high together with pcm_valid
interface snd_pdm_rx_if;
   import snd_pkg::*;
   pcm_t pcm_data;
   logic pcm_valid;
   logic pcm_ready;
   modport master(output pcm_data, output pcm_valid, input pcm_ready);
   modport slave(input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/snd_cic_decim.sv
// snd_cic_decim: CIC decimator (integrators at bit rate, decimation counter, registered comb pipeline)
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear of all filter state
//   tick_i     : one-cycle bit strobe; bit_i is the PDM bit (1 -> +1, 0 -> -1)
//   result_o   : raw comb result, valid while strobe_o is high
module snd_cic_decim
   import snd_pkg::*;
#(
   parameter int DECIM = 64,
   parameter int ACC_W = CIC_ORDER * $clog2(DECIM) + 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_i,
   input  logic                    tick_i,
   input  logic                    bit_i,
   output logic signed [ACC_W-1:0] result_o,
   output logic                    strobe_o
);
   localparam int DW = $clog2(DECIM);
   typedef logic signed [ACC_W-1:0] acc_t;
   acc_t integ_q [CIC_ORDER];
   acc_t integ_d [CIC_ORDER];
   acc_t comb_q  [CIC_ORDER];
   acc_t dly_q   [CIC_ORDER];
   acc_t comb_in [CIC_ORDER];
   logic [CIC_ORDER-1:0] vld_q, comb_en;
   logic [DW-1:0] dec_q;
   // Integrators chain combinationally so the captured value includes the current bit;
   // all sums wrap modulo 2^ACC_W, which the combs undo exactly.
   always_comb begin
      acc_t s;
      s = bit_i ? acc_t'(1) : acc_t'(-1);
      for (int k = 0; k < CIC_ORDER; k++) begin
         s = s + integ_q[k];
         integ_d[k] = s;
      end
      comb_in[0] = integ_d[CIC_ORDER-1];
      for (int k = 1; k < CIC_ORDER; k++) comb_in[k] = comb_q[k-1];
      comb_en = {vld_q[CIC_ORDER-2:0], tick_i && dec_q == DW'(DECIM - 1)};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dec_q <= '0;
         vld_q <= '0;
         for (int k = 0; k < CIC_ORDER; k++) begin
            integ_q[k] <= '0;
            comb_q[k]  <= '0;
            dly_q[k]   <= '0;
         end
      end else if (clr_i) begin
         dec_q <= '0;
         vld_q <= '0;
         for (int k = 0; k < CIC_ORDER; k++) begin
            integ_q[k] <= '0;
            comb_q[k]  <= '0;
            dly_q[k]   <= '0;
         end
      end else begin
         if (tick_i) begin
            dec_q <= dec_q + 1'b1;
            for (int k = 0; k < CIC_ORDER; k++) integ_q[k] <= integ_d[k];
         end
         vld_q <= comb_en;
         for (int k = 0; k < CIC_ORDER; k++) begin
            if (comb_en[k]) begin
               comb_q[k] <= comb_in[k] - dly_q[k];
               dly_q[k]  <= comb_in[k];
            end
         end
      end
   end
   assign result_o = comb_q[CIC_ORDER-1];
   assign strobe_o = vld_q[CIC_ORDER-1];
endmodule

// File: rtl/snd_pdm_rx.sv
// snd_pdm_rx: PDM-to-PCM receiver (bit clock generation, input sync, CIC decimation, PCM handshake)
//   clk, rst_n         : system clock, asynchronous active-low reset
//   enable             : run; low holds pdm_clk at 0 and clears filter state and pcm_valid
//   pdm_clk / pdm_in   : bit clock out to the PDM source, asynchronous data back
//   pcm (master)       : pcm_data / pcm_valid / pcm_ready sample stream
//   overrun / overrun_clr : sticky flag for an overwritten unconsumed sample, and its clear
//   Optional SND_PDM_RX_DC_BLOCK_EN: first-order DC-blocking high-pass after scaling (+1 clk latency)
module snd_pdm_rx
   import snd_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int DECIM   = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         enable,
   output logic         pdm_clk,
   input  logic         pdm_in,
   snd_pdm_rx_if.master pcm,
   output logic         overrun,
   input  logic         overrun_clr
);
   localparam int ACC_W = CIC_ORDER * $clog2(DECIM) + 2;
   localparam int SHIFT = CIC_ORDER * $clog2(DECIM) - 15;
   localparam int DIV_W = $clog2(CLK_DIV);
   logic [DIV_W-1:0] div_q, div_d;
   logic pclk_q, pclk_d;
   logic [1:0] sync_q;
   logic [1:0] settle_q, settle_d;
   logic valid_q, valid_d, ovr_q, ovr_d;
   pcm_t data_q, data_d, out_pcm;
   logic wrap, tick, load, cic_stb, out_stb;
   logic signed [ACC_W-1:0] cic_res, scaled;
   assign wrap = div_q == DIV_W'(CLK_DIV - 1);
   // Bit tick is the cycle whose edge takes pdm_clk from 1 to 0.
   assign tick = enable && wrap && pclk_q;
   snd_cic_decim #(.DECIM(DECIM)) u_cic (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (!enable),
      .tick_i   (tick),
      .bit_i    (sync_q[1]),
      .result_o (cic_res),
      .strobe_o (cic_stb)
   );
   assign scaled = cic_res >>> SHIFT;
`ifdef SND_PDM_RX_DC_BLOCK_EN
   logic signed [17:0] dcy_q, dcy_d;
   logic signed [19:0] dc_sum;
   pcm_t dcx_q, dcx_d;
   logic dcv_q;
   always_comb begin
      dcx_d  = sat16(32'(scaled));
      dc_sum = 20'(dcx_d) - 20'(dcx_q) + 20'(dcy_q) - 20'(dcy_q >>> DC_SHIFT);
      dcy_d  = (dc_sum > 20'sd131071) ? 18'sh1ffff : (dc_sum < -20'sd131072) ? 18'sh20000 : dc_sum[17:0];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcx_q <= '0;
         dcy_q <= '0;
         dcv_q <= 1'b0;
      end else if (!enable) begin
         dcx_q <= '0;
         dcy_q <= '0;
         dcv_q <= 1'b0;
      end else begin
         if (cic_stb) begin
            dcx_q <= dcx_d;
            dcy_q <= dcy_d;
         end
         dcv_q <= cic_stb;
      end
   end
   assign out_stb = dcv_q;
   assign out_pcm = sat16(32'(dcy_q));
`else
   assign out_stb = cic_stb;
   assign out_pcm = sat16(32'(scaled));
`endif
   // The first two decimated results carry partially filled history and are dropped.
   always_comb begin
      div_d    = (!enable || wrap) ? '0 : div_q + 1'b1;
      pclk_d   = enable && (wrap ^ pclk_q);
      load     = enable && out_stb && settle_q == 2'd2;
      settle_d = !enable ? 2'd0 : (out_stb && settle_q != 2'd2) ? settle_q + 2'd1 : settle_q;
      valid_d  = enable && (load || (valid_q && !pcm.pcm_ready));
      data_d   = load ? out_pcm : data_q;
      ovr_d    = (load && valid_q && !pcm.pcm_ready) || (ovr_q && !overrun_clr);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q    <= '0;
         pclk_q   <= 1'b0;
         sync_q   <= '0;
         settle_q <= '0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         ovr_q    <= 1'b0;
      end else begin
         div_q    <= div_d;
         pclk_q   <= pclk_d;
         sync_q   <= {sync_q[0], pdm_in};
         settle_q <= settle_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         ovr_q    <= ovr_d;
      end
   end
   assign pdm_clk       = pclk_q;
   assign pcm.pcm_data  = data_q;
   assign pcm.pcm_valid = valid_q;
   assign overrun       = ovr_q;
endmodule

// File: tb/tb_snd_pdm_rx.sv
// tb_snd_pdm_rx: directed self-checking bench for snd_pdm_rx (CLK_DIV=4, DECIM=64)
module tb_snd_pdm_rx;
   import snd_pkg::*;
   localparam int CLK_DIV = 4;
   localparam int DECIM   = 64;
   localparam int PERIOD  = 2 * CLK_DIV * DECIM;
   localparam int FIRST   = 3 * PERIOD + 4;
   logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, pdm_in = 1'b0, overrun_clr = 1'b0;
   logic pdm_clk, overrun;
   int mode = 1;
   int tests = 0, fails = 0;
   snd_pdm_rx_if pcm_if();
   snd_pdm_rx #(.CLK_DIV(CLK_DIV), .DECIM(DECIM)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .pdm_clk     (pdm_clk),
      .pdm_in      (pdm_in),
      .pcm         (pcm_if),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );
   always #5 clk = ~clk;
   // PDM source: new bit 1 ns after each pdm_clk rise; mode 0 = all 0, 1 = all 1, 2 = alternating
   initial forever begin
      @(posedge pdm_clk);
      #1;
      pdm_in = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : ~pdm_in;
   end
   task automatic wait_valid(output int cyc);
      cyc = 1;
      while (pcm_if.pcm_valid !== 1'b1 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
   endtask
   task automatic start(input int m);
      @(negedge clk);
      enable = 1'b0;
      mode = m;
      repeat (3) @(negedge clk);
      enable = 1'b1;
   endtask
   task automatic test_reset;
      pcm_if.pcm_ready = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (pdm_clk !== 1'b0) begin fails++; $display("FAIL reset_pdm_clk got %b want 0", pdm_clk); end
      tests++; if (pcm_if.pcm_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", pcm_if.pcm_valid); end
      tests++; if (pcm_if.pcm_data !== 16'sh0000) begin fails++; $display("FAIL reset_data got %0d want 0", pcm_if.pcm_data); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got %b want 0", overrun); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask
   task automatic test_clocking;
      int n, h, l;
      tests++; if (pdm_clk !== 1'b0) begin fails++; $display("FAIL idle_pdm_clk got %b want 0", pdm_clk); end
      enable = 1'b1;
      n = 0;
      while (pdm_clk !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      tests++; if (n !== CLK_DIV) begin fails++; $display("FAIL first_rise got %0d want %0d", n, CLK_DIV); end
      h = 0;
      while (pdm_clk === 1'b1 && h < 100) begin @(negedge clk); h++; end
      tests++; if (h !== CLK_DIV) begin fails++; $display("FAIL high_time got %0d want %0d", h, CLK_DIV); end
      l = 0;
      while (pdm_clk === 1'b0 && l < 100) begin @(negedge clk); l++; end
      tests++; if (l !== CLK_DIV) begin fails++; $display("FAIL low_time got %0d want %0d", l, CLK_DIV); end
      enable = 1'b0;
      @(negedge clk);
      tests++; if (pdm_clk !== 1'b0) begin fails++; $display("FAIL disable_pdm_clk got %b want 0", pdm_clk); end
   endtask
`ifdef SND_PDM_RX_DC_BLOCK_EN
   task automatic test_dc_block;
      pcm_t want [3] = '{16'sd32638, 16'sd32511, 16'sd32385};
      int n;
      pcm_if.pcm_ready = 1'b1;
      start(1);
      wait_valid(n);
      tests++; if (n !== FIRST + 1) begin fails++; $display("FAIL dc_latency got %0d want %0d", n, FIRST + 1); end
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin
            n = 0;
            do begin @(negedge clk); n++; end while (pcm_if.pcm_valid !== 1'b1 && n < 2000);
         end
         tests++; if (pcm_if.pcm_data !== want[i]) begin fails++; $display("FAIL dc_decay[%0d] got %0d want %0d", i, pcm_if.pcm_data, want[i]); end
      end
   endtask
`else
   task automatic test_dc_levels;
      int m [3] = '{1, 0, 2};
      pcm_t want [3] = '{16'sh7fff, 16'sh8000, 16'sh0000};
      int n;
      pcm_if.pcm_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         start(m[i]);
         wait_valid(n);
         tests++; if (n !== FIRST) begin fails++; $display("FAIL level%0d_latency got %0d want %0d", i, n, FIRST); end
         tests++; if (pcm_if.pcm_data !== want[i]) begin fails++; $display("FAIL level%0d_first got %0d want %0d", i, pcm_if.pcm_data, want[i]); end
         n = 0;
         do begin @(negedge clk); n++; end while (pcm_if.pcm_valid !== 1'b1 && n < 2000);
         tests++; if (n !== PERIOD) begin fails++; $display("FAIL level%0d_gap got %0d want %0d", i, n, PERIOD); end
         tests++; if (pcm_if.pcm_data !== want[i]) begin fails++; $display("FAIL level%0d_second got %0d want %0d", i, pcm_if.pcm_data, want[i]); end
      end
   endtask
   task automatic test_backpressure;
      int n;
      pcm_if.pcm_ready = 1'b0;
      start(1);
      wait_valid(n);
      tests++; if (pcm_if.pcm_data !== 16'sh7fff) begin fails++; $display("FAIL bp_first got %0d want 32767", pcm_if.pcm_data); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL bp_no_overrun got %b want 0", overrun); end
      mode = 0;
      repeat (PERIOD) @(negedge clk);
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL bp_overrun got %b want 1", overrun); end
      repeat (2 * PERIOD) @(negedge clk);
      tests++; if (pcm_if.pcm_data !== 16'sh8000) begin fails++; $display("FAIL bp_overwrite got %0d want -32768", pcm_if.pcm_data); end
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL bp_clear got %b want 0", overrun); end
      tests++; if (pcm_if.pcm_valid !== 1'b1) begin fails++; $display("FAIL bp_held got %b want 1", pcm_if.pcm_valid); end
      repeat (PERIOD - 2) @(negedge clk);
      pcm_if.pcm_ready = 1'b1;
      @(negedge clk);
      tests++; if (pcm_if.pcm_valid !== 1'b1) begin fails++; $display("FAIL bp_same_cycle_valid got %b want 1", pcm_if.pcm_valid); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL bp_same_cycle_overrun got %b want 0", overrun); end
      @(negedge clk);
      tests++; if (pcm_if.pcm_valid !== 1'b0) begin fails++; $display("FAIL bp_drop got %b want 0", pcm_if.pcm_valid); end
   endtask
   task automatic test_enable;
      int n;
      pcm_if.pcm_ready = 1'b0;
      wait_valid(n);
      tests++; if (pcm_if.pcm_valid !== 1'b1) begin fails++; $display("FAIL en_pre_valid got %b want 1", pcm_if.pcm_valid); end
      repeat (100) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      tests++; if (pdm_clk !== 1'b0) begin fails++; $display("FAIL en_off_pdm_clk got %b want 0", pdm_clk); end
      tests++; if (pcm_if.pcm_valid !== 1'b0) begin fails++; $display("FAIL en_off_valid got %b want 0", pcm_if.pcm_valid); end
      tests++; if (pcm_if.pcm_data !== 16'sh8000) begin fails++; $display("FAIL en_off_data got %0d want -32768", pcm_if.pcm_data); end
      repeat (20) @(negedge clk);
      tests++; if (pdm_clk !== 1'b0) begin fails++; $display("FAIL en_off_hold got %b want 0", pdm_clk); end
      mode = 2;
      pcm_if.pcm_ready = 1'b1;
      enable = 1'b1;
      wait_valid(n);
      tests++; if (n !== FIRST) begin fails++; $display("FAIL en_restart_latency got %0d want %0d", n, FIRST); end
      tests++; if (pcm_if.pcm_data !== 16'sh0000) begin fails++; $display("FAIL en_restart_data got %0d want 0", pcm_if.pcm_data); end
   endtask
`endif
   task automatic test_async_reset;
      int n;
      pcm_if.pcm_ready = 1'b0;
      start(1);
      wait_valid(n);
      repeat (PERIOD) @(negedge clk);
      tests++; if (overrun !== 1'b1) begin fails++; $display("FAIL ar_pre_overrun got %b want 1", overrun); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (pdm_clk !== 1'b0) begin fails++; $display("FAIL ar_pdm_clk got %b want 0", pdm_clk); end
      tests++; if (pcm_if.pcm_valid !== 1'b0) begin fails++; $display("FAIL ar_valid got %b want 0", pcm_if.pcm_valid); end
      tests++; if (pcm_if.pcm_data !== 16'sh0000) begin fails++; $display("FAIL ar_data got %0d want 0", pcm_if.pcm_data); end
      tests++; if (overrun !== 1'b0) begin fails++; $display("FAIL ar_overrun got %b want 0", overrun); end
   endtask
   initial begin
      pcm_if.pcm_ready = 1'b1;
      test_reset();
      test_clocking();
`ifdef SND_PDM_RX_DC_BLOCK_EN
      test_dc_block();
`else
      test_dc_levels();
      test_backpressure();
      test_enable();
`endif
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
